// File: rtl/seg7_axis_decoder.sv
`default_nettype none
// ============================================================================
// Module   : seg7_axis_decoder
// Brief    : Two-digit seven-segment pattern to binary decoder on AXI-Stream,
//            with a registered-ready skid output stage and error counter.
// Revision : 1.0 - initial release
// ============================================================================
module seg7_axis_decoder #(
    parameter int WIDTH      = 8,
    parameter int ACTIVE_LOW = 1,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [1:0][6:0]       s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [WIDTH-1:0]      m_data,
    output logic                  m_err,
    output logic [CNT_W-1:0]      err_count
);

    // {legal, digit} for a lit-high gfedcba pattern
    function automatic logic [4:0] f_seg(input logic [6:0] p);
        case (p)
            7'h3F:   f_seg = {1'b1, 4'd0};
            7'h06:   f_seg = {1'b1, 4'd1};
            7'h5B:   f_seg = {1'b1, 4'd2};
            7'h4F:   f_seg = {1'b1, 4'd3};
            7'h66:   f_seg = {1'b1, 4'd4};
            7'h6D:   f_seg = {1'b1, 4'd5};
            7'h7D:   f_seg = {1'b1, 4'd6};
            7'h07:   f_seg = {1'b1, 4'd7};
            7'h7F:   f_seg = {1'b1, 4'd8};
            7'h6F:   f_seg = {1'b1, 4'd9};
            default: f_seg = 5'b0;
        endcase
    endfunction

    logic [1:0][6:0] w_lit;
    logic [1:0][3:0] w_digit;
    logic [1:0]      w_legal;
    logic [1:0]      w_blank;

    for (genvar gi = 0; gi < 2; gi++) begin : g_digit
        if (ACTIVE_LOW != 0) begin : g_inv
            assign w_lit[gi] = ~s_data[gi];
        end else begin : g_pass
            assign w_lit[gi] = s_data[gi];
        end
        assign {w_legal[gi], w_digit[gi]} = f_seg(w_lit[gi]);
        assign w_blank[gi] = (w_lit[gi] == 7'h00);
    end

    // A blank tens digit decodes as 0 through the default digit value.
    logic             w_err;
    logic [6:0]       w_value;
    logic [WIDTH-1:0] w_beat_data;

    assign w_err       = !w_legal[0] || !(w_legal[1] || w_blank[1]);
    assign w_value     = 7'(w_digit[1]) * 7'd10 + 7'(w_digit[0]);
    assign w_beat_data = w_err ? '0 : WIDTH'(w_value);

    logic             r_s_ready;
    logic             r_main_valid;
    logic [WIDTH-1:0] r_main_data;
    logic             r_main_err;
    logic             r_skid_valid;
    logic [WIDTH-1:0] r_skid_data;
    logic             r_skid_err;
    logic [CNT_W-1:0] r_err_count;

    logic w_accept;
    logic w_drain;
    logic w_to_skid;
    logic w_skid_next;

    assign w_accept    = s_valid && r_s_ready;
    assign w_drain     = r_main_valid && m_ready;
    assign w_to_skid   = w_accept && r_main_valid && !m_ready;
    // Ready is the registered complement of next-cycle skid occupancy.
    assign w_skid_next = r_skid_valid ? !m_ready : w_to_skid;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_s_ready    <= 1'b0;
            r_main_valid <= 1'b0;
            r_main_data  <= '0;
            r_main_err   <= 1'b0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
            r_skid_err   <= 1'b0;
            r_err_count  <= '0;
        end else begin
            r_s_ready <= !w_skid_next;

            if (r_skid_valid) begin
                // Sink is held off while the skid is occupied.
                if (m_ready) begin
                    r_main_data  <= r_skid_data;
                    r_main_err   <= r_skid_err;
                    r_skid_valid <= 1'b0;
                end
            end else if (w_accept) begin
                if (!r_main_valid || m_ready) begin
                    r_main_valid <= 1'b1;
                    r_main_data  <= w_beat_data;
                    r_main_err   <= w_err;
                end else begin
                    r_skid_valid <= 1'b1;
                    r_skid_data  <= w_beat_data;
                    r_skid_err   <= w_err;
                end
            end else if (w_drain) begin
                r_main_valid <= 1'b0;
            end

            if (w_accept && w_err && (r_err_count != {CNT_W{1'b1}})) begin
                r_err_count <= r_err_count + 1'b1;
            end
        end
    end

    assign s_ready   = r_s_ready;
    assign m_valid   = r_main_valid;
    assign m_data    = r_main_data;
    assign m_err     = r_main_err;
    assign err_count = r_err_count;

endmodule
`default_nettype wire

// File: doc/seg7_axis_decoder.md
# seg7_axis_decoder

Stream-side decoder for two-digit seven-segment codes. Accepts one pair of segment patterns per AXI-Stream beat on its sink, converts the pair back to a binary value (tens × 10 + ones), and emits that value with an error flag on its source. It sits downstream of the adder's display-code output, giving loopback checking and readback of any seven-segment producer in the design. Full throughput (one beat per cycle) with a skid buffer so `s_ready` is registered.

## Interface
- `WIDTH`, 8, output value width; must be ≥ 7 (holds 0..99).
- `ACTIVE_LOW`, 1, 1 = segment bit low means lit; 0 = high means lit.
- `CNT_W`, 16, width of the error counter.

- `clk`  in  1  single clock, all logic on rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `s_valid`  in  1  sink beat valid.
- `s_ready`  out  1  sink ready (registered).
- `s_data`  in  [1:0][6:0]  `s_data[0]` ones digit, `s_data[1]` tens digit; bit0 = segment a … bit6 = segment g.
- `m_valid`  out  1  source beat valid.
- `m_ready`  in  1  source ready.
- `m_data`  out  WIDTH  decoded value, zero-extended.
- `m_err`  out  1  beat contained an illegal pattern.
- `err_count`  out  CNT_W  saturating count of accepted illegal beats.

## Operation
- Normalise: `p = ACTIVE_LOW ? ~s_data[i] : s_data[i]` (lit = 1).
- Legal lit patterns (gfedcba hex): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
- Tens digit: all-dark (00) is legal and decodes as 0 (leading blank). Ones digit: all-dark is illegal.
- Any other pattern on either digit is illegal: `m_err = 1`, `m_data = 0`.
- Legal: `m_data = tens*10 + ones`, 0..99, no overflow for WIDTH ≥ 7.
- Decode is combinational on `s_data`; the result is captured at the sink handshake (`s_valid && s_ready`).
- Output stage is a main register plus one skid register, each holding {data, err}:
  - Main empty, or main draining (`m_ready`): the accepted beat loads main.
  - Main full and stalled (`m_valid && !m_ready`) on an accepted beat: the beat loads skid, and `s_ready` goes 0 on the next cycle.
  - Main drains while skid is full: skid moves to main, skid empties, and `s_ready` returns to 1 on the next cycle.
- `m_data`/`m_err` are held stable while `m_valid && !m_ready` (AXI rule). Beats are never dropped or duplicated; order is preserved.
- `err_count` increments once per accepted illegal beat, at acceptance time. It saturates at all-ones.
- There is no internal timeout. Upstream may hold `s_valid` indefinitely; `s_data` is sampled only on the handshake.

## Timing
- Reset (rstn low, async): `m_valid = 0`, `m_data = 0`, `m_err = 0`, `err_count = 0`, skid empty, `s_ready = 0`.
- `s_ready` rises on the first rising `clk` edge after `rstn` deasserts.
- Latency: a beat accepted at edge N is presented with `m_valid = 1` after edge N (visible in cycle N+1).
- Throughput: with `m_ready` held at 1, one beat per cycle sustained, and `s_ready` stays 1.
- Backpressure:
  - `m_ready` low for k ≥ 1 cycles while the sink is streaming: exactly one extra beat is absorbed (skid), then `s_ready` = 0.
  - After `m_ready` returns, `s_ready` = 1 one cycle later.
- Simultaneous sink accept and source drain with skid empty: main is replaced in the same edge and `m_valid` stays 1 with no bubble.
- Reset mid-operation discards main and skid contents and clears the counter. No beat is emitted after reset until a new one is accepted.

## Test plan
- Reset: hold rstn low with `s_valid = 1` → all outputs at reset values, no handshake. Release rstn → `s_ready = 1` after one edge.
- Decode, `ACTIVE_LOW = 1`: `s_data[1] = ~7'h5B`, `s_data[0] = ~7'h66` → one cycle later `m_data = 24`, `m_err = 0`. Sweep all 0..99 with random values checked against a model.
- Leading blank: tens = `~7'h00`, ones = `~7'h07` → `m_data = 7`, `m_err = 0`. Ones = `~7'h00` → `m_err = 1`, `m_data = 0`, `err_count = 1`.
- Illegal pattern: tens = `~7'h01` → `m_err = 1`, `m_data = 0`. 70000 illegal beats with `CNT_W = 16` → `err_count = 65535`, held there.
- Backpressure: stream 20 values with `m_ready` toggled randomly, including 5-cycle stalls → output sequence equals input sequence. `s_ready` falls exactly one beat into a stall. Data is stable while stalled.
- Mid-stream reset with skid full → no stale beat appears afterward, and the next accepted value appears first.
